cpu_axi_bridge: RTL and testbench

CPU_AXI_BRIDGE -- requirements
Module: cpu_axi_bridge

---
 rtl/cpu_axi_bridge.sv | 262 ++++++++++++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_bridge.sv
// Bridges NUM_PORTS SRAM-like request ports onto one AXI master.
// Round-robin issue, one outstanding access per port, read-after-write guard.
module cpu_axi_bridge #(
   parameter int NUM_PORTS = 2,
   parameter int ID_WIDTH  = 4
) (
   input  logic                    clock,
   input  logic                    reset_,
   input  logic [NUM_PORTS-1:0]    port_request,
   input  logic [NUM_PORTS-1:0]    port_write,
   input  logic [2*NUM_PORTS-1:0]  port_size,
   input  logic [32*NUM_PORTS-1:0] port_address,
   input  logic [32*NUM_PORTS-1:0] port_write_data,
   output logic [32*NUM_PORTS-1:0] port_read_data,
   output logic [NUM_PORTS-1:0]    port_address_ready,
   output logic [NUM_PORTS-1:0]    port_data_ready,
   output logic [ID_WIDTH-1:0]     axi_read_address_id,
   output logic [31:0]             axi_read_address_address,
   output logic [7:0]              axi_read_address_length,
   output logic [2:0]              axi_read_address_size,
   output logic [1:0]              axi_read_address_burst,
   output logic [1:0]              axi_read_address_lock,
   output logic [3:0]              axi_read_address_cache,
   output logic [2:0]              axi_read_address_protection,
   output logic                    axi_read_address_valid,
   input  logic                    axi_read_address_ready,
   input  logic [ID_WIDTH-1:0]     axi_read_data_id,
   input  logic [31:0]             axi_read_data_data,
   input  logic [1:0]              axi_read_data_response,
   input  logic                    axi_read_data_last,
   input  logic                    axi_read_data_valid,
   output logic                    axi_read_data_ready,
   output logic [ID_WIDTH-1:0]     axi_write_address_id,
   output logic [31:0]             axi_write_address_address,
   output logic [7:0]              axi_write_address_length,
   output logic [2:0]              axi_write_address_size,
   output logic [1:0]              axi_write_address_burst,
   output logic [1:0]              axi_write_address_lock,
   output logic [3:0]              axi_write_address_cache,
   output logic [2:0]              axi_write_address_protection,
   output logic                    axi_write_address_valid,
   input  logic                    axi_write_address_ready,
   output logic [ID_WIDTH-1:0]     axi_write_data_id,
   output logic [31:0]             axi_write_data_data,
   output logic [3:0]              axi_write_data_strobe,
   output logic                    axi_write_data_last,
   output logic                    axi_write_data_valid,
   input  logic                    axi_write_data_ready,
   input  logic [ID_WIDTH-1:0]     axi_write_responce_id,
   input  logic [1:0]              axi_write_responce_responce,
   input  logic                    axi_write_responce_valid,
   output logic                    axi_write_responce_ready
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [NUM_PORTS-1:0] busy_q, busy_d, wr_q, wr_d, dready_q, dready_d;
   logic [29:0]          haz_q [NUM_PORTS];
   logic [29:0]          haz_d [NUM_PORTS];
   logic [31:0]          rdata_q [NUM_PORTS];
   logic [31:0]          rdata_d [NUM_PORTS];
   logic [PW-1:0]        ptr_q, ptr_d;
   logic                 ar_valid_q, ar_valid_d, aw_valid_q, aw_valid_d;
   logic                 w_valid_q, w_valid_d;
   logic [ID_WIDTH-1:0]  ar_id_q, ar_id_d, aw_id_q, aw_id_d;
   logic [31:0]          ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
   logic [1:0]           ar_size_q, ar_size_d, aw_size_q, aw_size_d;
   logic [31:0]          w_data_q, w_data_d;
   logic [3:0]           w_strb_q, w_strb_d;

   logic [NUM_PORTS-1:0] raw, elig, grant;
   logic                 gnt_any, gnt_wr, ar_free, w_free;
   logic [PW-1:0]        gnt_idx;
   logic [1:0]           gnt_size;
   logic [31:0]          gnt_addr, gnt_wdata;
   logic                 unused;

   function automatic logic [3:0] strobe(input logic [1:0] sz, input logic [1:0] a);
      case (sz)
         2'd0:    strobe = 4'b0001 << a;
         2'd1:    strobe = a[1] ? 4'b1100 : 4'b0011;
         default: strobe = 4'b1111;
      endcase
   endfunction

   assign ar_free = !ar_valid_q || axi_read_address_ready;
   assign w_free  = !aw_valid_q && !w_valid_q;

   // A read must not overtake any pending write to the same word.
   always_comb begin
      raw  = '0;
      elig = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         for (int j = 0; j < NUM_PORTS; j++)
            if (busy_q[j] && wr_q[j] && haz_q[j] == port_address[32*i+2 +: 30])
               raw[i] = 1'b1;
         elig[i] = reset_ && port_request[i] && !busy_q[i] &&
                   (port_write[i] ? w_free : (ar_free && !raw[i]));
      end
   end

   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      gnt_any   = 1'b0;
      gnt_idx   = '0;
      gnt_wr    = 1'b0;
      gnt_size  = '0;
      gnt_addr  = '0;
      gnt_wdata = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NUM_PORTS)
            idx = idx - NUM_PORTS;
         if (!gnt_any && elig[idx]) begin
            gnt_any    = 1'b1;
            grant[idx] = 1'b1;
            gnt_idx    = PW'(idx);
            gnt_wr     = port_write[idx];
            gnt_size   = port_size[2*idx +: 2];
            gnt_addr   = port_address[32*idx +: 32];
            gnt_wdata  = port_write_data[32*idx +: 32];
         end
      end
   end

   always_comb begin
      busy_d     = busy_q;
      wr_d       = wr_q;
      haz_d      = haz_q;
      rdata_d    = rdata_q;
      dready_d   = '0;
      ptr_d      = ptr_q;
      ar_valid_d = ar_valid_q && !axi_read_address_ready;
      ar_id_d    = ar_id_q;
      ar_addr_d  = ar_addr_q;
      ar_size_d  = ar_size_q;
      aw_valid_d = aw_valid_q && !axi_write_address_ready;
      aw_id_d    = aw_id_q;
      aw_addr_d  = aw_addr_q;
      aw_size_d  = aw_size_q;
      w_valid_d  = w_valid_q && !axi_write_data_ready;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (axi_read_data_valid && axi_read_data_id == ID_WIDTH'(k) &&
             busy_q[k] && !wr_q[k]) begin
            rdata_d[k]  = axi_read_data_data;
            dready_d[k] = 1'b1;
            busy_d[k]   = 1'b0;
         end
         if (axi_write_responce_valid && axi_write_responce_id == ID_WIDTH'(k) &&
             busy_q[k] && wr_q[k]) begin
            dready_d[k] = 1'b1;
            busy_d[k]   = 1'b0;
         end
      end
      if (gnt_any) begin
         busy_d[gnt_idx] = 1'b1;
         wr_d[gnt_idx]   = gnt_wr;
         ptr_d = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
         if (gnt_wr) begin
            aw_valid_d     = 1'b1;
            aw_id_d        = ID_WIDTH'(gnt_idx);
            aw_addr_d      = gnt_addr;
            aw_size_d      = gnt_size;
            w_valid_d      = 1'b1;
            w_data_d       = gnt_wdata;
            w_strb_d       = strobe(gnt_size, gnt_addr[1:0]);
            haz_d[gnt_idx] = gnt_addr[31:2];
         end else begin
            ar_valid_d = 1'b1;
            ar_id_d    = ID_WIDTH'(gnt_idx);
            ar_addr_d  = gnt_addr;
            ar_size_d  = gnt_size;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         busy_q     <= '0;
         wr_q       <= '0;
         dready_q   <= '0;
         ptr_q      <= '0;
         ar_valid_q <= 1'b0;
         ar_id_q    <= '0;
         ar_addr_q  <= '0;
         ar_size_q  <= '0;
         aw_valid_q <= 1'b0;
         aw_id_q    <= '0;
         aw_addr_q  <= '0;
         aw_size_q  <= '0;
         w_valid_q  <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            haz_q[i]   <= '0;
            rdata_q[i] <= '0;
         end
      end else begin
         busy_q     <= busy_d;
         wr_q       <= wr_d;
         dready_q   <= dready_d;
         ptr_q      <= ptr_d;
         ar_valid_q <= ar_valid_d;
         ar_id_q    <= ar_id_d;
         ar_addr_q  <= ar_addr_d;
         ar_size_q  <= ar_size_d;
         aw_valid_q <= aw_valid_d;
         aw_id_q    <= aw_id_d;
         aw_addr_q  <= aw_addr_d;
         aw_size_q  <= aw_size_d;
         w_valid_q  <= w_valid_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         haz_q      <= haz_d;
         rdata_q    <= rdata_d;
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rd
      assign port_read_data[32*i +: 32] = rdata_q[i];
   end

   assign port_address_ready = grant;
   assign port_data_ready    = dready_q;

   assign axi_read_address_id          = ar_id_q;
   assign axi_read_address_address     = ar_addr_q;
   assign axi_read_address_length      = 8'd0;
   assign axi_read_address_size        = {1'b0, ar_size_q};
   assign axi_read_address_burst       = 2'b01;
   assign axi_read_address_lock        = 2'b00;
   assign axi_read_address_cache       = 4'd0;
   assign axi_read_address_protection  = 3'd0;
   assign axi_read_address_valid       = ar_valid_q;
   assign axi_read_data_ready          = 1'b1;

   assign axi_write_address_id         = aw_id_q;
   assign axi_write_address_address    = aw_addr_q;
   assign axi_write_address_length     = 8'd0;
   assign axi_write_address_size       = {1'b0, aw_size_q};
   assign axi_write_address_burst      = 2'b01;
   assign axi_write_address_lock       = 2'b00;
   assign axi_write_address_cache      = 4'd0;
   assign axi_write_address_protection = 3'd0;
   assign axi_write_address_valid      = aw_valid_q;

   assign axi_write_data_id            = aw_id_q;
   assign axi_write_data_data          = w_data_q;
   assign axi_write_data_strobe        = w_strb_q;
   assign axi_write_data_last          = 1'b1;
   assign axi_write_data_valid         = w_valid_q;
   assign axi_write_responce_ready     = 1'b1;

   // Response codes carry no meaning for the SRAM-like ports.
   assign unused = ^{axi_read_data_response, axi_read_data_last,
                     axi_write_responce_responce};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed and randomized bench for cpu_axi_bridge with a
// transaction-level reference model of ports, AXI slots and responses.
module tb_cpu_axi_bridge;

  logic        clock = 1'b0;
  logic        reset_;
  logic [1:0]  port_request, port_write;
  logic [3:0]  port_size;
  logic [63:0] port_address, port_write_data, port_read_data;
  logic [1:0]  port_address_ready, port_data_ready;
  logic [3:0]  ar_id, r_id, aw_id, w_id, b_id;
  logic [31:0] ar_addr, aw_addr, r_data, w_data;
  logic [7:0]  ar_len, aw_len;
  logic [2:0]  ar_size, aw_size, ar_prot, aw_prot;
  logic [1:0]  ar_burst, aw_burst, ar_lock, aw_lock, r_resp, b_resp;
  logic [3:0]  ar_cache, aw_cache, w_strb;
  logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
  logic        aw_valid, aw_ready, w_last, w_valid, w_ready;
  logic        b_valid, b_ready;

  int errors = 0;
  int checks = 0;

  bit          m_busy [2];
  bit          m_isw [2];
  logic [31:0] m_addr [2];
  bit          m_rd_iss [2];
  bit          m_aw_done [2];
  bit          m_w_done [2];
  logic [31:0] m_rdata [2];
  logic [1:0]  m_dready;
  int          m_ptr;
  bit          m_ar_full, m_aw_full, m_w_full;
  int          m_ar_id, m_aw_id, m_w_id;
  logic [31:0] m_ar_addr, m_aw_addr, m_w_data;
  logic [2:0]  m_ar_size, m_aw_size;
  logic [3:0]  m_w_strb;

  cpu_axi_bridge #(.NUM_PORTS(2), .ID_WIDTH(4)) dut (
    .clock(clock), .reset_(reset_),
    .port_request(port_request), .port_write(port_write),
    .port_size(port_size), .port_address(port_address),
    .port_write_data(port_write_data), .port_read_data(port_read_data),
    .port_address_ready(port_address_ready),
    .port_data_ready(port_data_ready),
    .axi_read_address_id(ar_id), .axi_read_address_address(ar_addr),
    .axi_read_address_length(ar_len), .axi_read_address_size(ar_size),
    .axi_read_address_burst(ar_burst), .axi_read_address_lock(ar_lock),
    .axi_read_address_cache(ar_cache),
    .axi_read_address_protection(ar_prot),
    .axi_read_address_valid(ar_valid), .axi_read_address_ready(ar_ready),
    .axi_read_data_id(r_id), .axi_read_data_data(r_data),
    .axi_read_data_response(r_resp), .axi_read_data_last(r_last),
    .axi_read_data_valid(r_valid), .axi_read_data_ready(r_ready),
    .axi_write_address_id(aw_id), .axi_write_address_address(aw_addr),
    .axi_write_address_length(aw_len), .axi_write_address_size(aw_size),
    .axi_write_address_burst(aw_burst), .axi_write_address_lock(aw_lock),
    .axi_write_address_cache(aw_cache),
    .axi_write_address_protection(aw_prot),
    .axi_write_address_valid(aw_valid),
    .axi_write_address_ready(aw_ready),
    .axi_write_data_id(w_id), .axi_write_data_data(w_data),
    .axi_write_data_strobe(w_strb), .axi_write_data_last(w_last),
    .axi_write_data_valid(w_valid), .axi_write_data_ready(w_ready),
    .axi_write_responce_id(b_id),
    .axi_write_responce_responce(b_resp),
    .axi_write_responce_valid(b_valid),
    .axi_write_responce_ready(b_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] o,
                     input logic [127:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic edge_;
    @(posedge clock);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  function automatic logic [3:0] exp_strb(input logic [1:0] sz,
                                          input logic [31:0] a);
    int n, off;
    n   = (sz >= 2) ? 4 : (1 << sz);
    off = int'(a[1:0]) & ~(n - 1) & 3;
    return 4'(((1 << n) - 1) << off);
  endfunction

  task automatic model_clear;
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_isw[i] = 0; m_addr[i] = '0; m_rd_iss[i] = 0;
      m_aw_done[i] = 0; m_w_done[i] = 0; m_rdata[i] = '0;
    end
    m_dready = '0; m_ptr = 0;
    m_ar_full = 0; m_aw_full = 0; m_w_full = 0;
    m_ar_id = 0; m_aw_id = 0; m_w_id = 0;
    m_ar_addr = '0; m_aw_addr = '0; m_w_data = '0;
    m_ar_size = '0; m_aw_size = '0; m_w_strb = '0;
  endtask

  task automatic rand_step(input bit allow_req);
    logic [1:0]  req, wr, nd, exp_rdy;
    logic [31:0] a [2];
    logic [1:0]  sz [2];
    logic [31:0] wd [2];
    bit          el [2];
    bit          haz;
    int          g, rk, bk, s, idx;
    for (int i = 0; i < 2; i++) begin
      req[i] = allow_req && ($urandom_range(0, 2) != 0);
      wr[i]  = 1'($urandom_range(0, 1));
      a[i]   = 32'h5000 + 32'($urandom_range(0, 31));
      sz[i]  = 2'($urandom_range(0, 3));
      wd[i]  = $urandom;
      port_address[32*i +: 32]    = a[i];
      port_write_data[32*i +: 32] = wd[i];
      port_size[2*i +: 2]         = sz[i];
    end
    port_request = req;
    port_write   = wr;
    ar_ready = allow_req ? 1'($urandom_range(0, 1)) : 1'b1;
    aw_ready = allow_req ? 1'($urandom_range(0, 1)) : 1'b1;
    w_ready  = allow_req ? 1'($urandom_range(0, 1)) : 1'b1;
    rk = -1;
    bk = -1;
    s  = $urandom_range(0, 1);
    if ($urandom_range(0, 1) == 1)
      for (int t = 0; t < 2; t++)
        if (rk < 0 && m_rd_iss[(s + t) % 2]) rk = (s + t) % 2;
    if ($urandom_range(0, 1) == 1)
      for (int t = 0; t < 2; t++)
        if (bk < 0 && m_aw_done[(s + t) % 2] &&
            m_w_done[(s + t) % 2])
          bk = (s + t) % 2;
    r_resp = 2'($urandom_range(0, 3));
    r_data = $urandom;
    b_resp = 2'($urandom_range(0, 3));
    if (rk >= 0) begin
      r_valid = 1'b1; r_id = 4'(rk);
    end else begin
      r_valid = ($urandom_range(0, 5) == 0);
      r_id    = 4'($urandom_range(2, 15));
    end
    if (bk >= 0) begin
      b_valid = 1'b1; b_id = 4'(bk);
    end else begin
      b_valid = ($urandom_range(0, 5) == 0);
      b_id    = 4'($urandom_range(2, 15));
    end
    settle();
    for (int i = 0; i < 2; i++) begin
      haz = 0;
      for (int j = 0; j < 2; j++)
        if (m_busy[j] && m_isw[j] && m_addr[j][31:2] == a[i][31:2])
          haz = 1;
      el[i] = req[i] && !m_busy[i] &&
              (wr[i] ? (!m_aw_full && !m_w_full)
                     : ((!m_ar_full || ar_ready) && !haz));
    end
    g = -1;
    for (int t = 0; t < 2; t++) begin
      idx = (m_ptr + t) % 2;
      if (g < 0 && el[idx]) g = idx;
    end
    exp_rdy = (g < 0) ? 2'b00 : (2'b01 << g);
    chk("rnd_addr_ready", port_address_ready, exp_rdy);
    chk("rnd_data_ready", port_data_ready, m_dready);
    chk("rnd_rdata0", port_read_data[31:0], m_rdata[0]);
    chk("rnd_rdata1", port_read_data[63:32], m_rdata[1]);
    chk("rnd_ar_valid", ar_valid, m_ar_full);
    if (m_ar_full) begin
      chk("rnd_ar_id", ar_id, 4'(m_ar_id));
      chk("rnd_ar_addr", ar_addr, m_ar_addr);
      chk("rnd_ar_size", ar_size, m_ar_size);
    end
    chk("rnd_aw_valid", aw_valid, m_aw_full);
    if (m_aw_full) begin
      chk("rnd_aw_id", aw_id, 4'(m_aw_id));
      chk("rnd_aw_addr", aw_addr, m_aw_addr);
      chk("rnd_aw_size", aw_size, m_aw_size);
    end
    chk("rnd_w_valid", w_valid, m_w_full);
    if (m_w_full) begin
      chk("rnd_w_id", w_id, 4'(m_w_id));
      chk("rnd_w_data", w_data, m_w_data);
      chk("rnd_w_strb", w_strb, m_w_strb);
    end
    nd = '0;
    if (m_ar_full && ar_ready) begin
      m_rd_iss[m_ar_id] = 1; m_ar_full = 0;
    end
    if (m_aw_full && aw_ready) begin
      m_aw_done[m_aw_id] = 1; m_aw_full = 0;
    end
    if (m_w_full && w_ready) begin
      m_w_done[m_w_id] = 1; m_w_full = 0;
    end
    if (rk >= 0) begin
      m_busy[rk] = 0; m_rd_iss[rk] = 0;
      m_rdata[rk] = r_data; nd[rk] = 1'b1;
    end
    if (bk >= 0) begin
      m_busy[bk] = 0; m_aw_done[bk] = 0;
      m_w_done[bk] = 0; nd[bk] = 1'b1;
    end
    if (g >= 0) begin
      m_busy[g] = 1; m_isw[g] = wr[g]; m_addr[g] = a[g];
      m_ptr = (g + 1) % 2;
      if (wr[g]) begin
        m_aw_full = 1; m_aw_id = g; m_aw_addr = a[g];
        m_aw_size = {1'b0, sz[g]};
        m_w_full = 1; m_w_id = g; m_w_data = wd[g];
        m_w_strb = exp_strb(sz[g], a[g]);
      end else begin
        m_ar_full = 1; m_ar_id = g; m_ar_addr = a[g];
        m_ar_size = {1'b0, sz[g]};
      end
    end
    m_dready = nd;
    edge_();
  endtask

  initial begin
    reset_ = 1'b0;
    port_request = 2'b11; port_write = '0; port_size = '0;
    port_address = '0; port_write_data = '0;
    ar_ready = 0; aw_ready = 0; w_ready = 0;
    r_valid = 0; r_id = '0; r_data = '0; r_resp = '0; r_last = 1'b1;
    b_valid = 0; b_id = '0; b_resp = '0;
    edge_(); edge_(); settle();
    chk("rst_addr_ready", port_address_ready, 2'b00);
    chk("rst_data_ready", port_data_ready, 2'b00);
    chk("rst_ar_valid", ar_valid, 1'b0);
    chk("rst_aw_valid", aw_valid, 1'b0);
    chk("rst_w_valid", w_valid, 1'b0);
    chk("rst_rdata", port_read_data, 64'h0);
    chk("r_ready_const", r_ready, 1'b1);
    chk("b_ready_const", b_ready, 1'b1);
    edge_();
    reset_ = 1'b1;
    port_request = '0;
    edge_();

    port_request = 2'b01; port_address[31:0] = 32'h1000;
    port_size[1:0] = 2'd2;
    settle();
    chk("rd_grant", port_address_ready, 2'b01);
    edge_();
    port_request = '0; ar_ready = 1;
    settle();
    chk("rd_ar_valid", ar_valid, 1'b1);
    chk("rd_ar_id", ar_id, 4'd0);
    chk("rd_ar_addr", ar_addr, 32'h1000);
    chk("rd_ar_size", ar_size, 3'd2);
    chk("rd_ar_fixed",
        {ar_len, ar_burst, ar_lock, ar_cache, ar_prot},
        {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
    edge_();
    ar_ready = 0;
    settle();
    chk("rd_ar_drop", ar_valid, 1'b0);
    r_valid = 1; r_id = 4'd0; r_data = 32'hDEADBEEF;
    edge_();
    r_valid = 0;
    settle();
    chk("rd_dready", port_data_ready, 2'b01);
    chk("rd_data", port_read_data[31:0], 32'hDEADBEEF);
    edge_(); settle();
    chk("rd_pulse_end", port_data_ready, 2'b00);

    port_request = 2'b10; port_write = 2'b10;
    port_address[63:32] = 32'h2003;
    port_size[3:2] = 2'd0; port_write_data[63:32] = 32'h11223344;
    settle();
    chk("wr_grant", port_address_ready, 2'b10);
    edge_();
    port_request = '0; aw_ready = 1; w_ready = 1;
    settle();
    chk("wr_valids", {aw_valid, w_valid}, 2'b11);
    chk("wr_ids", {aw_id, w_id}, 8'h11);
    chk("wr_aw_addr", aw_addr, 32'h2003);
    chk("wr_aw_size", aw_size, 3'd0);
    chk("wr_aw_fixed",
        {aw_len, aw_burst, aw_lock, aw_cache, aw_prot},
        {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
    chk("wr_strb", w_strb, 4'b1000);
    chk("wr_data", w_data, 32'h11223344);
    chk("wr_last", w_last, 1'b1);
    edge_();
    aw_ready = 0; w_ready = 0;
    settle();
    chk("wr_drop", {aw_valid, w_valid}, 2'b00);
    b_valid = 1; b_id = 4'd1;
    edge_();
    b_valid = 0;
    settle();
    chk("wr_dready", port_data_ready, 2'b10);

    port_request = 2'b01; port_write = 2'b01;
    port_address[31:0] = 32'h3000;
    port_size[1:0] = 2'd2; port_write_data[31:0] = 32'h0000ABCD;
    settle();
    chk("raw_wr_grant", port_address_ready, 2'b01);
    edge_();
    port_request = '0; aw_ready = 1; w_ready = 1;
    edge_();
    aw_ready = 0; w_ready = 0;
    port_request = 2'b10; port_write = 2'b00;
    port_address[63:32] = 32'h3002;
    port_size[3:2] = 2'd2;
    settle();
    chk("raw_hold0", port_address_ready, 2'b00);
    edge_(); settle();
    chk("raw_hold1", port_address_ready, 2'b00);
    b_valid = 1; b_id = 4'd0;
    settle();
    chk("raw_hold_b", port_address_ready, 2'b00);
    edge_();
    b_valid = 0;
    settle();
    chk("raw_b_dready", port_data_ready, 2'b01);
    chk("raw_release", port_address_ready, 2'b10);
    edge_();
    port_request = '0;
    settle();
    chk("raw_ar", {ar_valid, ar_id, ar_addr},
        {1'b1, 4'd1, 32'h3002});
    ar_ready = 1;
    edge_();
    ar_ready = 0; r_valid = 1; r_id = 4'd1; r_data = 32'hCAFE0001;
    edge_();
    r_valid = 0;
    settle();
    chk("raw_rd_data", {port_data_ready, port_read_data[63:32]},
        {2'b10, 32'hCAFE0001});

    port_request = 2'b11; port_write = 2'b00;
    port_address = {32'h200, 32'h100}; port_size = 4'hA; ar_ready = 1;
    settle();
    chk("rr0", port_address_ready, 2'b01);
    edge_(); settle();
    chk("rr1", port_address_ready, 2'b10);
    chk("rr1_ar_id", ar_id, 4'd0);
    edge_();
    port_request = '0;
    settle();
    chk("rr_ar_id1", {ar_valid, ar_id}, {1'b1, 4'd1});
    edge_(); settle();
    chk("rr_ar_empty", ar_valid, 1'b0);
    r_valid = 1; r_id = 4'd1; r_data = 32'hBBBB0001;
    edge_();
    r_id = 4'd0; r_data = 32'hAAAA0000;
    settle();
    chk("ooo_port1", {port_data_ready, port_read_data[63:32]},
        {2'b10, 32'hBBBB0001});
    edge_();
    r_valid = 0;
    settle();
    chk("ooo_port0", {port_data_ready, port_read_data[31:0]},
        {2'b01, 32'hAAAA0000});
    port_request = 2'b11;
    settle();
    chk("rr2", port_address_ready, 2'b01);
    edge_(); settle();
    chk("rr3", port_address_ready, 2'b10);
    edge_();
    port_request = '0;
    edge_();
    ar_ready = 0; r_valid = 1; r_id = 4'd0;
    edge_();
    r_id = 4'd1;
    edge_();
    r_valid = 0;
    edge_();

    port_request = 2'b01; port_address[31:0] = 32'h4000;
    edge_();
    port_request = '0;
    settle();
    chk("mid_ar_valid", ar_valid, 1'b1);
    edge_();
    reset_ = 1'b0; port_request = 2'b01;
    settle();
    chk("mid_rst_outs",
        {ar_valid, aw_valid, w_valid, port_address_ready,
         port_data_ready}, 7'd0);
    chk("mid_rst_rdata", port_read_data, 64'h0);
    edge_();
    reset_ = 1'b1; port_request = '0;
    r_valid = 1; r_id = 4'd0; r_data = 32'h00000055;
    edge_();
    r_valid = 0;
    settle();
    chk("mid_no_pulse", port_data_ready, 2'b00);
    chk("mid_rdata", port_read_data, 64'h0);
    chk("mid_ar_idle", ar_valid, 1'b0);
    edge_();

    model_clear();
    for (int c = 0; c < 600; c++) rand_step(1'b1);
    for (int c = 0; c < 40; c++) rand_step(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
